// File: rtl/simple_pkg.sv
// simple_pkg: shared fetch FSM states, instruction field codes and widths for the SIMPLE pipeline
package simple_pkg;
  localparam int INST_W = 16;
  localparam int PC_W = 16;
  localparam logic [1:0] FMT_ALU = 2'b11;
  localparam logic [3:0] OP_HLT = 4'b1111;
  typedef enum logic [1:0] {BOOT, RUN, HALT} fetch_state_t;
  function automatic logic is_hlt(input logic [INST_W-1:0] w);
    return w[15:14] == FMT_ALU && w[7:4] == OP_HLT;
  endfunction
endpackage

// File: rtl/fetch_pc.sv
// fetch_pc: program counter with reset load, redirect, increment and hold
module fetch_pc
  import simple_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inc,
  input  logic            load,
  input  logic [PC_W-1:0] target,
  output logic [PC_W-1:0] pc
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= RESET_PC;
    else pc <= load ? target : inc ? pc + 1'b1 : pc;
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage; FETCH_HALT_EN enables stopping on a captured HLT
module fetch_unit
  import simple_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 16'h0000,
  parameter int              IMEM_AW  = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic               imem_en,
  input  logic [INST_W-1:0]  imem_rdata,
  input  logic               stall,
  input  logic               br_taken,
  input  logic [PC_W-1:0]    br_target,
  output logic [INST_W-1:0]  inst,
  output logic [PC_W-1:0]    inst_pc,
  output logic               inst_valid,
  output logic               halted
);
`ifdef FETCH_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif
  fetch_state_t state;
  logic [PC_W-1:0] pc, fetch_pc_q;
  logic squash, redirect, advance, capture, hlt_hit;
  always_comb begin
    redirect = state != HALT && br_taken;
    advance = state == BOOT || (state == RUN && !stall);
    imem_en = redirect || advance;
    capture = state == RUN && !stall && !br_taken;
    hlt_hit = HALT_EN && capture && !squash && is_hlt(imem_rdata);
  end
  assign imem_addr = pc[IMEM_AW-1:0];
  fetch_pc #(.RESET_PC(RESET_PC)) u_pc (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (advance),
    .load  (redirect),
    .target(br_target),
    .pc    (pc)
  );
  // fetch_pc_q tracks the address whose data is on imem_rdata this cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= BOOT;
      inst       <= '0;
      inst_pc    <= '0;
      inst_valid <= 1'b0;
      squash     <= 1'b0;
      halted     <= 1'b0;
      fetch_pc_q <= RESET_PC;
    end else begin
      if (imem_en) fetch_pc_q <= pc;
      if (redirect) begin
        inst_valid <= 1'b0;
        squash     <= 1'b1;
        state      <= RUN;
      end else if (capture) begin
        inst       <= imem_rdata;
        inst_pc    <= fetch_pc_q;
        inst_valid <= !squash;
        squash     <= hlt_hit;
        if (hlt_hit) begin
          state  <= HALT;
          halted <= 1'b1;
        end
      end else if (state == BOOT) begin
        state <= RUN;
      end else if (state == HALT) begin
        inst_valid <= 1'b0;
      end
    end
  end
endmodule
